// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin arbiter sharing one I2C master between config requesters
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GUARD_CYCLES   = 16
) (
  input  logic                 i_sysclk,
  input  logic                 i_arst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_m_en,
  input  logic [NUM_REQ-1:0]   i_m_wr,
  input  logic [NUM_REQ-1:0]   i_last,
  input  logic [7*NUM_REQ-1:0] i_addr,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_last,
  output logic [7:0]           o_rdata,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic [1:0]           o_err_id,
  output logic                 o_m_en,
  output logic                 o_m_wr,
  output logic                 o_m_last,
  output logic [6:0]           o_m_addr,
  output logic [7:0]           o_m_data,
  input  logic                 i_m_ack,
  input  logic                 i_m_last,
  input  logic [7:0]           i_m_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [15:0]  wd_q, wd_d;
  logic [7:0]   guard_q, guard_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic         timeout_d;
  logic [1:0]   err_id_d;

  // Requester inputs padded to four slots so the owner index can select them uniformly
  logic [3:0]   req_pad, en_pad, wr_pad, last_pad;
  logic [27:0]  addr_pad;
  logic [31:0]  data_pad;
  logic [6:0]   addr_arr [4];
  logic [7:0]   data_arr [4];

  logic         sel_found;
  logic [1:0]   sel_idx;
  logic [1:0]   cand;
  logic         in_grant;

  assign req_pad  = 4'(i_req);
  assign en_pad   = 4'(i_m_en);
  assign wr_pad   = 4'(i_m_wr);
  assign last_pad = 4'(i_last);
  assign addr_pad = 28'(i_addr);
  assign data_pad = 32'(i_data);
  assign in_grant = (state_q == ST_GRANT);

  // Split the packed address/data buses into per-requester slots
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addr_arr[k] = addr_pad[7*k +: 7];
      data_arr[k] = data_pad[8*k +: 8];
    end
  end

  // Round-robin pick: first pending request after the last owner, wrapping at NUM_REQ
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = 2'((int'(ptr_q) + i) % NUM_REQ);
      if (!sel_found && req_pad[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // State, pointer, counters and registered status outputs
  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= 2'(NUM_REQ - 1);
      wd_q      <= '0;
      guard_q   <= '0;
      o_gnt     <= '0;
      o_timeout <= 1'b0;
      o_err_id  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      guard_q   <= guard_d;
      o_gnt     <= gnt_d;
      o_timeout <= timeout_d;
      o_err_id  <= err_id_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, watch the owner in GRANT, hold the bus quiet in GUARD
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    wd_d      = wd_q;
    guard_d   = guard_q;
    gnt_d     = o_gnt;
    timeout_d = 1'b0;
    err_id_d  = o_err_id;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d = ST_GRANT;
          owner_d = sel_idx;
          wd_d    = '0;
          for (int k = 0; k < NUM_REQ; k++) begin
            gnt_d[k] = (sel_idx == 2'(k));
          end
        end
      end
      ST_GRANT: begin
        if (!req_pad[owner_q]) begin
          // Owner finished; a simultaneous watchdog expiry is not reported
          state_d = ST_GUARD;
          ptr_d   = owner_q;
          gnt_d   = '0;
          guard_d = '0;
        end else if (!i_m_ack && (wd_q == 16'(TIMEOUT_CYCLES - 1))) begin
          state_d   = ST_GUARD;
          ptr_d     = owner_q;
          gnt_d     = '0;
          guard_d   = '0;
          timeout_d = 1'b1;
          err_id_d  = owner_q;
        end else if (i_m_ack) begin
          wd_d = '0;
        end else if (wd_q != 16'hFFFF) begin
          wd_d = wd_q + 16'd1;
        end
      end
      ST_GUARD: begin
        if (guard_q == 8'(GUARD_CYCLES - 1)) begin
          state_d = ST_IDLE;
          guard_d = '0;
        end else begin
          guard_d = guard_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Command mux toward the wrapper and response routing back to the owner
  always_comb begin
    o_m_en   = 1'b0;
    o_m_wr   = 1'b0;
    o_m_last = 1'b0;
    o_m_addr = '0;
    o_m_data = '0;
    o_ack    = '0;
    o_last   = '0;
    if (in_grant) begin
      o_m_en   = en_pad[owner_q] & req_pad[owner_q];
      o_m_wr   = wr_pad[owner_q];
      o_m_last = last_pad[owner_q];
      o_m_addr = addr_arr[owner_q];
      o_m_data = data_arr[owner_q];
      o_ack    = o_gnt & {NUM_REQ{i_m_ack}};
      o_last   = o_gnt & {NUM_REQ{i_m_last}};
    end
  end

  assign o_rdata = i_m_rdata;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - directed vector bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

  logic clk;
  logic arst;
  int   tests = 0;
  int   fails = 0;

  // Instance A: two requesters, short watchdog, 16-cycle guard
  logic [1:0]  req_a, men_a, mwr_a, last_a;
  logic [13:0] addr_a;
  logic [15:0] data_a;
  logic [1:0]  gnt_a, ack_a, olast_a, err_a;
  logic [7:0]  rdata_a, m_data_a, mrdata_a;
  logic        busy_a, tmo_a, m_en_a, m_wr_a, m_last_a, mack_a, mlast_a;
  logic [6:0]  m_addr_a;

  // Instance B: four requesters, 4-cycle guard
  logic [3:0]  req_b, men_b, mwr_b, last_b;
  logic [27:0] addr_b;
  logic [31:0] data_b;
  logic [3:0]  gnt_b, ack_b, olast_b;
  logic [1:0]  err_b;
  logic [7:0]  rdata_b, m_data_b, mrdata_b;
  logic        busy_b, tmo_b, m_en_b, m_wr_b, m_last_b, mack_b, mlast_b;
  logic [6:0]  m_addr_b;

  i2c_master_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(100), .GUARD_CYCLES(16)) u_a (
    .i_sysclk(clk), .i_arst(arst),
    .i_req(req_a), .i_m_en(men_a), .i_m_wr(mwr_a), .i_last(last_a),
    .i_addr(addr_a), .i_data(data_a),
    .o_gnt(gnt_a), .o_ack(ack_a), .o_last(olast_a), .o_rdata(rdata_a),
    .o_busy(busy_a), .o_timeout(tmo_a), .o_err_id(err_a),
    .o_m_en(m_en_a), .o_m_wr(m_wr_a), .o_m_last(m_last_a),
    .o_m_addr(m_addr_a), .o_m_data(m_data_a),
    .i_m_ack(mack_a), .i_m_last(mlast_a), .i_m_rdata(mrdata_a)
  );

  i2c_master_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(100), .GUARD_CYCLES(4)) u_b (
    .i_sysclk(clk), .i_arst(arst),
    .i_req(req_b), .i_m_en(men_b), .i_m_wr(mwr_b), .i_last(last_b),
    .i_addr(addr_b), .i_data(data_b),
    .o_gnt(gnt_b), .o_ack(ack_b), .o_last(olast_b), .o_rdata(rdata_b),
    .o_busy(busy_b), .o_timeout(tmo_b), .o_err_id(err_b),
    .o_m_en(m_en_b), .o_m_wr(m_wr_b), .o_m_last(m_last_b),
    .o_m_addr(m_addr_b), .o_m_data(m_data_b),
    .i_m_ack(mack_b), .i_m_last(mlast_b), .i_m_rdata(mrdata_b)
  );

  typedef struct {
    logic [1:0]  req, men, mwr, last;
    logic [13:0] addr;
    logic [15:0] data;
    logic        mack, mlast;
    logic [7:0]  rdata;
    logic        e_en, e_wr, e_last;
    logic [6:0]  e_addr;
    logic [7:0]  e_data;
    logic [1:0]  e_ack, e_olast;
  } vec_t;

  vec_t vecs [5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL tb_watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(input bit inst_b, input logic [3:0] exp, input string nm);
    int n = 0;
    logic [3:0] g;
    g = inst_b ? gnt_b : 4'(gnt_a);
    while (g == 4'h0 && n < 40) begin
      tick();
      n++;
      g = inst_b ? gnt_b : 4'(gnt_a);
    end
    check(nm, 32'(g), 32'(exp));
  endtask

  task automatic wait_idle(input bit inst_b, input string nm);
    int n = 0;
    logic b;
    b = inst_b ? busy_b : busy_a;
    while (b && n < 60) begin
      tick();
      n++;
      b = inst_b ? busy_b : busy_a;
    end
    check(nm, 32'(b), 32'h0);
  endtask

  initial begin
    int   n;
    logic bad;
    logic [1:0] e;

    //          req    men    mwr    last   addr               data              mack  mlast rdata  en    wr    last  addr   data   ack    olast
    vecs[0] = '{2'b11, 2'b10, 2'b10, 2'b00, {7'h45, 7'h12}, {8'hC3, 8'h3C}, 1'b1, 1'b0, 8'h99, 1'b1, 1'b1, 1'b0, 7'h45, 8'hC3, 2'b10, 2'b00};
    vecs[1] = '{2'b11, 2'b01, 2'b01, 2'b01, {7'h7F, 7'h00}, {8'h00, 8'hFF}, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 7'h7F, 8'h00, 2'b00, 2'b10};
    vecs[2] = '{2'b10, 2'b10, 2'b00, 2'b10, {7'h01, 7'h7E}, {8'h80, 8'h7F}, 1'b1, 1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 7'h01, 8'h80, 2'b10, 2'b10};
    vecs[3] = '{2'b01, 2'b11, 2'b11, 2'b11, {7'h2A, 7'h55}, {8'h12, 8'h34}, 1'b1, 1'b0, 8'hE7, 1'b0, 1'b1, 1'b1, 7'h2A, 8'h12, 2'b10, 2'b00};
    vecs[4] = '{2'b11, 2'b11, 2'b10, 2'b00, {7'h33, 7'h44}, {8'hAB, 8'hCD}, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'h33, 8'hAB, 2'b00, 2'b00};

    arst = 1'b1;
    req_a = '0; men_a = 2'b11; mwr_a = '0; last_a = '0;
    addr_a = {7'h22, 7'h11}; data_a = {8'h5A, 8'hA5};
    mack_a = 1'b0; mlast_a = 1'b0; mrdata_a = '0;
    req_b = '0; men_b = 4'hF; mwr_b = '0; last_b = '0;
    addr_b = {7'h33, 7'h22, 7'h11, 7'h00}; data_b = 32'hD4C3B2A1;
    mack_b = 1'b0; mlast_b = 1'b0; mrdata_b = '0;

    repeat (3) tick();
    check("rst_gnt", 32'(gnt_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_tmo", 32'(tmo_a), 32'h0);
    check("rst_err", 32'(err_a), 32'h0);
    check("rst_m_en", 32'(m_en_a), 32'h0);
    check("rst_m_addr", 32'(m_addr_a), 32'h0);
    check("rst_gnt_b", 32'(gnt_b), 32'h0);
    arst = 1'b0;
    tick();

    // T1: single requester, two acked bytes, release and guard gap
    req_a = 2'b01;
    #1;
    check("t1_gnt_latency", 32'(gnt_a), 32'h0);
    tick();
    check("t1_gnt", 32'(gnt_a), 32'h1);
    check("t1_busy", 32'(busy_a), 32'h1);
    check("t1_m_en", 32'(m_en_a), 32'h1);
    check("t1_m_addr", 32'(m_addr_a), 32'h11);
    check("t1_m_data", 32'(m_data_a), 32'hA5);
    mack_a = 1'b1;
    #1;
    check("t1_ack", 32'(ack_a), 32'h1);
    tick();
    mack_a = 1'b0;
    tick();
    mack_a = 1'b1; mlast_a = 1'b1;
    #1;
    check("t1_last", 32'(olast_a), 32'h1);
    tick();
    mack_a = 1'b0; mlast_a = 1'b0;
    data_a[7:0] = 8'h3C;
    #1;
    check("t1_data_track", 32'(m_data_a), 32'h3C);
    req_a = 2'b00;
    tick();
    check("t1_release_gnt", 32'(gnt_a), 32'h0);
    n = 0;
    bad = 1'b0;
    while (busy_a && n < 40) begin
      if (m_en_a) bad = 1'b1;
      n++;
      tick();
    end
    check("t1_guard_len", 32'(n), 32'd16);
    check("t1_guard_en", 32'(bad), 32'h0);
    check("t1_idle", 32'(busy_a), 32'h0);
    data_a = {8'h5A, 8'hA5};

    // Table: combinational mux/routing while requester 1 owns the bus
    req_a = 2'b10;
    tick();
    check("tbl_gnt", 32'(gnt_a), 32'h2);
    for (int i = 0; i < 5; i++) begin
      req_a = vecs[i].req; men_a = vecs[i].men; mwr_a = vecs[i].mwr; last_a = vecs[i].last;
      addr_a = vecs[i].addr; data_a = vecs[i].data;
      mack_a = vecs[i].mack; mlast_a = vecs[i].mlast; mrdata_a = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d_en", i), 32'(m_en_a), 32'(vecs[i].e_en));
      check($sformatf("vec%0d_wr", i), 32'(m_wr_a), 32'(vecs[i].e_wr));
      check($sformatf("vec%0d_last", i), 32'(m_last_a), 32'(vecs[i].e_last));
      check($sformatf("vec%0d_addr", i), 32'(m_addr_a), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_data", i), 32'(m_data_a), 32'(vecs[i].e_data));
      check($sformatf("vec%0d_ack", i), 32'(ack_a), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d_olast", i), 32'(olast_a), 32'(vecs[i].e_olast));
      check($sformatf("vec%0d_rdata", i), 32'(rdata_a), 32'(vecs[i].rdata));
    end
    req_a = 2'b10; men_a = 2'b11; mwr_a = '0; last_a = '0;
    addr_a = {7'h22, 7'h11}; data_a = {8'h5A, 8'hA5};
    mack_a = 1'b0; mlast_a = 1'b0; mrdata_a = '0;
    req_a = 2'b00;
    tick();
    wait_idle(1'b0, "tbl_idle");

    // T2: both request together; strict alternation, ack only to owner
    req_a = 2'b11;
    for (int i = 0; i < 4; i++) begin
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_gnt(1'b0, 4'(e), $sformatf("t2_order%0d", i));
      mack_a = 1'b1;
      #1;
      check($sformatf("t2_ack%0d", i), 32'(ack_a), 32'(e));
      mack_a = 1'b0;
      tick();
      req_a = req_a & ~gnt_a;
      tick();
      req_a = 2'b11;
    end
    req_a = 2'b00;
    wait_idle(1'b0, "t2_idle");

    // T3: owner 1 never acked -> watchdog release at GRANT cycle 100
    req_a = 2'b10;
    wait_gnt(1'b0, 4'h2, "t3_gnt1");
    req_a = 2'b11;
    bad = 1'b0;
    for (int i = 0; i < 99; i++) begin
      if (tmo_a || gnt_a != 2'b10) bad = 1'b1;
      tick();
    end
    if (tmo_a || gnt_a != 2'b10) bad = 1'b1;
    check("t3_no_early_tmo", 32'(bad), 32'h0);
    tick();
    check("t3_tmo_pulse", 32'(tmo_a), 32'h1);
    check("t3_err_id", 32'(err_a), 32'h1);
    check("t3_gnt_drop", 32'(gnt_a), 32'h0);
    tick();
    check("t3_tmo_1cyc", 32'(tmo_a), 32'h0);
    wait_gnt(1'b0, 4'h1, "t3_next_owner");
    req_a = 2'b10;
    tick();
    wait_gnt(1'b0, 4'h2, "t3_reentry");

    // T4: ack in cycle 99 restarts the watchdog
    repeat (98) tick();
    mack_a = 1'b1;
    tick();
    mack_a = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tmo_a || gnt_a != 2'b10) bad = 1'b1;
      tick();
    end
    check("t4_no_tmo", 32'(bad), 32'h0);
    req_a = 2'b00;
    wait_idle(1'b0, "t4_idle");

    // T5: asynchronous reset mid-GRANT
    req_a = 2'b10;
    wait_gnt(1'b0, 4'h2, "t5_gnt");
    check("t5_m_en_pre", 32'(m_en_a), 32'h1);
    req_a = 2'b11;
    #2;
    arst = 1'b1;
    #1;
    check("t5_m_en_rst", 32'(m_en_a), 32'h0);
    check("t5_gnt_rst", 32'(gnt_a), 32'h0);
    check("t5_err_rst", 32'(err_a), 32'h0);
    tick();
    tick();
    arst = 1'b0;
    wait_gnt(1'b0, 4'h1, "t5_req0_wins");
    req_a = 2'b00;
    wait_idle(1'b0, "t5_idle");

    // T6: four requesters, reqs 1 and 3 with pointer at 1 -> 3,1,3
    req_b = 4'b0010;
    wait_gnt(1'b1, 4'b0010, "t6_setup");
    req_b = 4'b0000;
    tick();
    req_b = 4'b1010;
    wait_gnt(1'b1, 4'b1000, "t6_g0");
    check("t6_addr3", 32'(m_addr_b), 32'h33);
    req_b = 4'b0010;
    tick();
    req_b = 4'b1010;
    wait_gnt(1'b1, 4'b0010, "t6_g1");
    check("t6_addr1", 32'(m_addr_b), 32'h11);
    req_b = 4'b1000;
    tick();
    req_b = 4'b1010;
    wait_gnt(1'b1, 4'b1000, "t6_g2");
    req_b = 4'b0000;
    wait_idle(1'b1, "t6_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
